// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM states, default geometry and address field helpers for the instruction cache
package icache_pkg;
   localparam int DEF_ADDR_W = 64;
   localparam int DEF_INST_W = 32;
   localparam int DEF_NUM_SETS = 8;
   localparam int DEF_NUM_WAYS = 2;
   localparam int DEF_LINE_WORDS = 4;
   localparam int WB = $clog2(DEF_LINE_WORDS);
   localparam int IB = $clog2(DEF_NUM_SETS);
   localparam int TB = DEF_ADDR_W - IB - WB - 2;

   typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL} state_e;

   function automatic logic [63:0] field(input logic [63:0] a, input int lo, input int w);
      return (a >> lo) & ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [63:0] word_of(input logic [63:0] a, input int wb);
      return field(a, 2, wb);
   endfunction

   function automatic logic [63:0] idx_of(input logic [63:0] a, input int wb, input int ib);
      return field(a, wb + 2, ib);
   endfunction

   function automatic logic [63:0] tag_of(input logic [63:0] a, input int wb, input int ib);
      return a >> (wb + ib + 2);
   endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one way of the cache; valid/tag/data arrays with combinational read and a single write port
module icache_way
   import icache_pkg::*;
#(
   parameter int DATA_W = DEF_INST_W,
   parameter int TAG_W = TB,
   parameter int IDX_W = IB,
   parameter int WORD_W = WB
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  clr_i,
   input  logic [IDX_W-1:0]      rd_idx_i,
   input  logic [WORD_W-1:0]     rd_word_i,
   input  logic [IDX_W-1:0]      wr_idx_i,
   input  logic [WORD_W-1:0]     wr_word_i,
   input  logic [DATA_W-1:0]     wr_data_i,
   input  logic                  data_we_i,
   input  logic                  tag_we_i,
   input  logic [TAG_W-1:0]      tag_i,
   output logic [2**IDX_W-1:0]   valid_o,
   output logic                  rd_valid_o,
   output logic [TAG_W-1:0]      rd_tag_o,
   output logic [DATA_W-1:0]     rd_data_o
);
   logic [2**IDX_W-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q [2**IDX_W];
   logic [DATA_W-1:0]   data_q [2**(IDX_W+WORD_W)];

   always_ff @(posedge Clk)
      if (!Rst) valid_q <= '0;
      else if (clr_i) valid_q <= '0;
      else if (tag_we_i) valid_q[wr_idx_i] <= 1'b1;

   // Tag and data storage carry no reset; valid bits alone gate their use.
   always_ff @(posedge Clk) begin
      if (tag_we_i) tag_q[wr_idx_i] <= tag_i;
      if (data_we_i) data_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
   end

   assign valid_o = valid_q;
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o = tag_q[rd_idx_i];
   assign rd_data_o = data_q[{rd_idx_i, rd_word_i}];
endmodule

// File: rtl/icache_set_assoc.sv
// icache_set_assoc: blocking N-way set-associative instruction cache with burst line refill
module icache_set_assoc
   import icache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int INST_W = DEF_INST_W,
   parameter int NUM_SETS = DEF_NUM_SETS,
   parameter int NUM_WAYS = DEF_NUM_WAYS,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ReqValid,
   input  logic [ADDR_W-1:0] ReqPc,
   input  logic              FlushIn,
   output logic [INST_W-1:0] InstOut,
   output logic              Hit,
   output logic              Stall,
   output logic              CacheFull,
   output logic              MemReqValid,
   input  logic              MemReqReady,
   output logic [ADDR_W-1:0] MemReqAddr,
   input  logic              MemRespValid,
   input  logic [INST_W-1:0] MemRespData
);
   localparam int WORD_B = $clog2(LINE_WORDS);
   localparam int IDX_B = $clog2(NUM_SETS);
   localparam int TAG_B = ADDR_W - IDX_B - WORD_B - 2;
   localparam int VW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;

   state_e              state_q, state_d;
   logic [WORD_B-1:0]   cnt_q;
   logic [IDX_B-1:0]    miss_idx_q;
   logic [TAG_B-1:0]    miss_tag_q;
   logic [VW-1:0]       victim_q;
   logic [VW-1:0]       rr_q [NUM_SETS];
   logic                flush_pend_q;
   logic [ADDR_W-1:0]   line_q;

   logic [63:0]         pc64;
   logic [IDX_B-1:0]    req_idx;
   logic [WORD_B-1:0]   req_word;
   logic [TAG_B-1:0]    req_tag;
   logic [NUM_WAYS-1:0] way_hit, way_rvalid;
   logic [TAG_B-1:0]    way_rtag [NUM_WAYS];
   logic [INST_W-1:0]   way_rdata [NUM_WAYS];
   logic [NUM_SETS-1:0] way_valid [NUM_WAYS];
   logic [INST_W-1:0]   inst;
   logic [VW-1:0]       victim;
   logic                refill_done, flushing, clr_all, tag_we, start_miss;

   assign pc64 = 64'(ReqPc);
   assign req_idx = IDX_B'(idx_of(pc64, WORD_B, IDX_B));
   assign req_word = WORD_B'(word_of(pc64, WORD_B));
   assign req_tag = TAG_B'(tag_of(pc64, WORD_B, IDX_B));

   assign refill_done = state_q == REFILL && MemRespValid && cnt_q == WORD_B'(LINE_WORDS - 1);
   assign flushing = flush_pend_q | FlushIn;
   assign clr_all = (state_q == IDLE && FlushIn) || (refill_done && flushing);
   assign tag_we = refill_done && !flushing;
   assign start_miss = state_q == IDLE && ReqValid && !(|way_hit) && !FlushIn;

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      icache_way #(
         .DATA_W(INST_W), .TAG_W(TAG_B), .IDX_W(IDX_B), .WORD_W(WORD_B)
      ) u_way (
         .Clk(Clk), .Rst(Rst), .clr_i(clr_all),
         .rd_idx_i(req_idx), .rd_word_i(req_word),
         .wr_idx_i(miss_idx_q), .wr_word_i(cnt_q), .wr_data_i(MemRespData),
         .data_we_i(state_q == REFILL && MemRespValid && victim_q == VW'(w)),
         .tag_we_i(tag_we && victim_q == VW'(w)), .tag_i(miss_tag_q),
         .valid_o(way_valid[w]), .rd_valid_o(way_rvalid[w]),
         .rd_tag_o(way_rtag[w]), .rd_data_o(way_rdata[w])
      );
      assign way_hit[w] = way_rvalid[w] && way_rtag[w] == req_tag;
   end

   // Lowest invalid way wins; with a full set the round-robin pointer picks.
   always_comb begin
      victim = rr_q[req_idx];
      for (int w = NUM_WAYS - 1; w >= 0; w--) if (!way_rvalid[w]) victim = VW'(w);
   end

   always_comb begin
      inst = '0;
      CacheFull = 1'b1;
      for (int w = 0; w < NUM_WAYS; w++) begin
         inst |= way_hit[w] ? way_rdata[w] : '0;
         CacheFull &= &way_valid[w];
      end
   end

   assign Hit = ReqValid && state_q == IDLE && !FlushIn && |way_hit;
   assign InstOut = Hit ? inst : '0;
   assign Stall = (ReqValid && !Hit) || state_q != IDLE;
   assign MemReqAddr = line_q;

   always_ff @(posedge Clk) state_q <= !Rst ? IDLE : state_d;

   always_comb begin
      state_d = state_q;
      MemReqValid = 1'b0;
      case (state_q)
         IDLE: if (start_miss) state_d = MISS_REQ;
         MISS_REQ: begin
            MemReqValid = 1'b1;
            if (MemReqReady) state_d = REFILL;
         end
         REFILL: if (refill_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk)
      if (!Rst) begin
         cnt_q <= '0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
         victim_q <= '0;
         flush_pend_q <= 1'b0;
         line_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
      end else begin
         if (start_miss) begin
            line_q <= {ReqPc[ADDR_W-1:WORD_B+2], (WORD_B + 2)'(0)};
            miss_idx_q <= req_idx;
            miss_tag_q <= req_tag;
            victim_q <= victim;
         end
         if (state_q == MISS_REQ && MemReqReady) cnt_q <= '0;
         else if (state_q == REFILL && MemRespValid) cnt_q <= cnt_q + 1'b1;
         // The burst cannot be aborted, so a fence.i seen mid-miss is held until the line lands.
         if (refill_done) flush_pend_q <= 1'b0;
         else if (state_q != IDLE && FlushIn) flush_pend_q <= 1'b1;
         if (refill_done)
            rr_q[miss_idx_q] <= rr_q[miss_idx_q] == VW'(NUM_WAYS - 1) ? '0 : rr_q[miss_idx_q] + 1'b1;
      end
endmodule
